// File: rtl/ecg_win_sched.sv
// ecg_win_sched: fetches ECG sample words from a 1-cycle-latency ROM in
// ascending order and emits overlapping WIN-bit windows, advancing STRIDE
// bits per accepted window, over a valid/ready handshake. A frame runs
// from a start pulse to a one-cycle done pulse. Abort and reset return
// the block to IDLE.
module ecg_win_sched #(
    parameter int DEPTH  = 29,
    parameter int ADDR_W = 5,
    parameter int STRIDE = 2,
    parameter int WIN    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [6:0]        win_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic              win_last,
    output logic [8:0]        win_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL0, S_FILL1, S_FILL2, S_STREAM, S_RQ, S_CAP, S_DONE
    } state_t;

    localparam int              NWIN       = (DEPTH * 32 - WIN) / STRIDE + 1;
    localparam logic [8:0]      LAST_IDX   = 9'(NWIN - 1);
    localparam logic [ADDR_W:0] DEPTH_N    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] NXT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] NXT_TWO    = (ADDR_W + 1)'(2);
    localparam logic [5:0]      STRIDE_N   = 6'(STRIDE);
    // A single-word frame has no second word to prefetch during FILL1.
    localparam bit              MULTI_WORD = (DEPTH > 1);

    state_t          state_q, state_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [5:0]      pos_q, pos_d;
    logic [ADDR_W:0] nxt_q, nxt_d;
    logic [8:0]      idx_q, idx_d;

    logic            more_words;
    logic [5:0]      pos_adv;
    logic [63:0]     view;

    // nxt is one bit wider than the address so it can hold DEPTH itself.
    assign more_words = (nxt_q < DEPTH_N);
    // pos never exceeds 31 in STREAM, so pos+STRIDE fits in 6 bits.
    assign pos_adv    = pos_q + STRIDE_N;
    // Left-align the window so its earliest bit lands in view[63].
    assign view       = {hi_q, lo_q} << pos_q;

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            pos_q   <= '0;
            nxt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pos_q   <= pos_d;
            nxt_q   <= nxt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and buffer bookkeeping; abort overrides everything else.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pos_d   = pos_q;
        nxt_d   = nxt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_FILL0;
                    pos_d   = '0;
                    nxt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_FILL0: state_d = S_FILL1;
            S_FILL1: begin
                hi_d    = rom_data;
                nxt_d   = NXT_TWO;
                state_d = S_FILL2;
            end
            S_FILL2: begin
                lo_d    = MULTI_WORD ? rom_data : 32'd0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (win_ready) begin
                    pos_d = pos_adv;
                    idx_d = idx_q + 9'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else if (pos_adv >= 6'd32) begin
                        // hi is fully consumed: slide lo up and refill lo.
                        hi_d    = lo_q;
                        pos_d   = pos_adv - 6'd32;
                        state_d = S_RQ;
                    end
                end
            end
            S_RQ: state_d = S_CAP;
            S_CAP: begin
                if (more_words) begin
                    lo_d  = rom_data;
                    nxt_d = nxt_q + NXT_ONE;
                end else begin
                    // Past the last word the tail is zero-filled.
                    lo_d = '0;
                end
                state_d = S_STREAM;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            // Drop the frame; a handshake in this cycle is discarded.
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            pos_d   = pos_q;
            nxt_d   = nxt_q;
            idx_d   = idx_q;
        end
    end

    // Outputs decoded from the current state only; all zero in IDLE.
    always_comb begin
        rom_en    = 1'b0;
        rom_addr  = '0;
        win_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_FILL0: rom_en = 1'b1;
            S_FILL1: begin
                rom_en   = MULTI_WORD;
                rom_addr = MULTI_WORD ? ADDR_W'(1) : '0;
            end
            S_STREAM: win_valid = 1'b1;
            S_RQ: begin
                rom_en   = more_words;
                rom_addr = more_words ? nxt_q[ADDR_W-1:0] : '0;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        busy     = (state_q != S_IDLE);
        win_data = win_valid ? view[63 -: WIN] : '0;
        win_last = win_valid && (idx_q == LAST_IDX);
        win_idx  = busy ? idx_q : '0;
    end

endmodule

// File: tb/tb_ecg_win_sched.sv
// Bench for ecg_win_sched: two instances (default parameters and
// STRIDE=4/DEPTH=2). When a start is accepted the whole expected window
// sequence of the frame is computed from the ROM contents as a plain bit
// stream and queued; per-instance monitors compare every presented window,
// the ROM address sequence, the done pulse and idle outputs.
module tb_ecg_win_sched;

    localparam int DEPTH_A = 29;
    localparam int STRIDE_A = 2;
    localparam int DEPTH_B = 2;
    localparam int STRIDE_B = 4;

    typedef struct {
        logic [8:0] idx;
        logic [6:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals (default parameters)
    logic        rst_a, start_a, abort_a, win_ready_a;
    logic        rom_en_a, win_valid_a, win_last_a, busy_a, done_a;
    logic [4:0]  rom_addr_a;
    logic [31:0] rom_data_a;
    logic [6:0]  win_data_a;
    logic [8:0]  win_idx_a;
    // Instance B signals (STRIDE=4, DEPTH=2)
    logic        rst_b, start_b, abort_b, win_ready_b;
    logic        rom_en_b, win_valid_b, win_last_b, busy_b, done_b;
    logic [4:0]  rom_addr_b;
    logic [31:0] rom_data_b;
    logic [6:0]  win_data_b;
    logic [8:0]  win_idx_b;

    logic [31:0] rom_a [0:31];
    logic [31:0] rom_b [0:31];

    logic [25:0] outs_a, outs_b;
    assign outs_a = {rom_en_a, rom_addr_a, win_data_a, win_valid_a, win_last_a, win_idx_a, busy_a, done_a};
    assign outs_b = {rom_en_b, rom_addr_b, win_data_b, win_valid_b, win_last_b, win_idx_b, busy_b, done_b};

    ecg_win_sched dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a),
        .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .win_data(win_data_a), .win_valid(win_valid_a), .win_ready(win_ready_a),
        .win_last(win_last_a), .win_idx(win_idx_a), .busy(busy_a), .done(done_a)
    );

    ecg_win_sched #(.DEPTH(DEPTH_B), .ADDR_W(5), .STRIDE(STRIDE_B), .WIN(7)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b),
        .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .win_data(win_data_b), .win_valid(win_valid_b), .win_ready(win_ready_b),
        .win_last(win_last_b), .win_idx(win_idx_b), .busy(busy_b), .done(done_b)
    );

    // ROM models with one cycle of read latency
    always @(posedge clk) begin
        if (rom_en_a) rom_data_a <= rom_a[rom_addr_a];
        if (rom_en_b) rom_data_b <= rom_b[rom_addr_b];
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the frame is the concatenation of the ROM words,
    // MSB first, followed by zeros; window k starts at bit k*stride.
    function automatic logic stream_bit(input int sel, input int b);
        int wi;
        logic [31:0] word;
        wi = b / 32;
        if (wi >= ((sel == 0) ? DEPTH_A : DEPTH_B)) return 1'b0;
        word = (sel == 0) ? rom_a[wi] : rom_b[wi];
        return word[31 - (b % 32)];
    endfunction

    function automatic logic [6:0] model_win(input int sel, input int stride, input int k);
        logic [6:0] w;
        for (int j = 0; j < 7; j++) w[6-j] = stream_bit(sel, k * stride + j);
        return w;
    endfunction

    exp_t exp_a[$];
    exp_t exp_b[$];
    int nwin_a = 0, nwin_b = 0;

    function automatic void push_frame(input int sel);
        int depth, stride, nw;
        exp_t e;
        depth  = (sel == 0) ? DEPTH_A : DEPTH_B;
        stride = (sel == 0) ? STRIDE_A : STRIDE_B;
        nw = (depth * 32 - 7) / stride + 1;
        for (int k = 0; k < nw; k++) begin
            e.idx  = 9'(k);
            e.data = model_win(sel, stride, k);
            e.last = (k == nw - 1);
            if (sel == 0) exp_a.push_back(e);
            else exp_b.push_back(e);
        end
        if (sel == 0) nwin_a = nw;
        else nwin_b = nw;
    endfunction

    // Monitor A
    bit done_due_a = 0, after_done_a = 0, hold_a = 0;
    int addr_exp_a = 0, hs_a = 0, reads_a = 0;
    exp_t ea;
    always @(negedge clk) begin
        if (rst_a) begin
            exp_a.delete();
            done_due_a = 0; after_done_a = 0; hold_a = 0;
        end else begin
            check("done_a", 32'(done_a), 32'(done_due_a));
            if (done_due_a) begin
                check("handshakes_a", 32'(hs_a), 32'(nwin_a));
                check("rom_reads_a", 32'(reads_a), 32'(DEPTH_A));
                $display("frame A complete: %0d windows, %0d rom reads", hs_a, reads_a);
            end
            if (after_done_a) check("busy_after_done_a", 32'(busy_a), 32'd0);
            after_done_a = done_due_a;
            done_due_a = 0;
            if (hold_a) check("valid_hold_a", 32'(win_valid_a), 32'd1);
            if (!busy_a) check("idle_outputs_a", 32'(outs_a), 32'd0);
            if (rom_en_a) begin
                check("rom_addr_a", 32'(rom_addr_a), 32'(addr_exp_a));
                addr_exp_a++;
                reads_a++;
            end else begin
                check("rom_addr_off_a", 32'(rom_addr_a), 32'd0);
            end
            if (win_valid_a) begin
                if (exp_a.size() == 0) begin
                    check("unexpected_valid_a", 32'd1, 32'd0);
                end else begin
                    ea = exp_a[0];
                    check("win_data_a", 32'(win_data_a), 32'(ea.data));
                    check("win_idx_a", 32'(win_idx_a), 32'(ea.idx));
                    check("win_last_a", 32'(win_last_a), 32'(ea.last));
                    if (win_ready_a && !abort_a) begin
                        ea = exp_a.pop_front();
                        hs_a++;
                        if (ea.last) done_due_a = 1;
                    end
                end
            end
            hold_a = win_valid_a && !win_ready_a && !abort_a;
            if (abort_a && busy_a) begin
                exp_a.delete();
                done_due_a = 0;
                hold_a = 0;
            end
            if (!busy_a && start_a && !abort_a) begin
                push_frame(0);
                addr_exp_a = 0; hs_a = 0; reads_a = 0;
            end
        end
    end

    // Monitor B
    bit done_due_b = 0, after_done_b = 0, hold_b = 0;
    int addr_exp_b = 0, hs_b = 0, reads_b = 0;
    exp_t eb;
    always @(negedge clk) begin
        if (rst_b) begin
            exp_b.delete();
            done_due_b = 0; after_done_b = 0; hold_b = 0;
        end else begin
            check("done_b", 32'(done_b), 32'(done_due_b));
            if (done_due_b) begin
                check("handshakes_b", 32'(hs_b), 32'(nwin_b));
                check("rom_reads_b", 32'(reads_b), 32'(DEPTH_B));
                $display("frame B complete: %0d windows, %0d rom reads", hs_b, reads_b);
            end
            if (after_done_b) check("busy_after_done_b", 32'(busy_b), 32'd0);
            after_done_b = done_due_b;
            done_due_b = 0;
            if (hold_b) check("valid_hold_b", 32'(win_valid_b), 32'd1);
            if (!busy_b) check("idle_outputs_b", 32'(outs_b), 32'd0);
            if (rom_en_b) begin
                check("rom_addr_b", 32'(rom_addr_b), 32'(addr_exp_b));
                addr_exp_b++;
                reads_b++;
            end else begin
                check("rom_addr_off_b", 32'(rom_addr_b), 32'd0);
            end
            if (win_valid_b) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_valid_b", 32'd1, 32'd0);
                end else begin
                    eb = exp_b[0];
                    check("win_data_b", 32'(win_data_b), 32'(eb.data));
                    check("win_idx_b", 32'(win_idx_b), 32'(eb.idx));
                    check("win_last_b", 32'(win_last_b), 32'(eb.last));
                    if (win_ready_b && !abort_b) begin
                        eb = exp_b.pop_front();
                        hs_b++;
                        if (eb.last) done_due_b = 1;
                    end
                end
            end
            hold_b = win_valid_b && !win_ready_b && !abort_b;
            if (abort_b && busy_b) begin
                exp_b.delete();
                done_due_b = 0;
                hold_b = 0;
            end
            if (!busy_b && start_b && !abort_b) begin
                push_frame(1);
                addr_exp_b = 0; hs_b = 0; reads_b = 0;
            end
        end
    end

    // Pulse start in the next cycle; returns during FILL0.
    task automatic start_frame(input int sel);
        @(posedge clk); #1;
        if (sel == 0) start_a = 1'b1;
        else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Run until done is seen, driving ready; counts busy cycles without a window.
    task automatic wait_done(input int sel, input bit rnd, output int bubbles);
        bit got;
        got = 0;
        bubbles = 0;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? done_a : done_b) begin
                got = 1;
            end else if (sel == 0) begin
                if (busy_a && !win_valid_a) bubbles++;
                win_ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                if (busy_b && !win_valid_b) bubbles++;
                win_ready_b = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (!got) check("timeout_done", 32'd0, 32'd1);
    endtask

    int bub;
    bit found;

    initial begin
        rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0; win_ready_a = 1'b1;
        rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; win_ready_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rom_a[i] = $urandom;
            rom_b[i] = $urandom;
        end
        rom_a[0] = 32'hA5A5A5A5;
        rom_a[1] = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_a", 32'(outs_a), 32'd0);
        check("reset_outs_b", 32'(outs_b), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Basic fetch timing and a full frame at ready=1
        start_frame(0);
        check("fill0_rom", 32'({rom_en_a, rom_addr_a}), 32'({1'b1, 5'd0}));
        @(posedge clk); #1;
        check("fill1_rom", 32'({rom_en_a, rom_addr_a}), 32'({1'b1, 5'd1}));
        @(posedge clk); #1;
        check("fill2_no_valid", 32'(win_valid_a), 32'd0);
        @(posedge clk); #1;
        check("first_window", 32'({win_valid_a, win_data_a}), 32'({1'b1, 7'h52}));
        wait_done(0, 1'b0, bub);
        check("refill_bubbles_a", 32'(bub), 32'd56);

        // Back-to-back frame under random backpressure
        start_frame(0);
        wait_done(0, 1'b1, bub);

        // start and abort together in IDLE stay in IDLE
        @(posedge clk); #1;
        start_a = 1'b1; abort_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; abort_a = 1'b0;
        check("start_abort_idle", 32'(busy_a), 32'd0);

        // Abort at window 100
        win_ready_a = 1'b1;
        start_frame(0);
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(posedge clk); #1;
            if (win_valid_a && win_idx_a == 9'd100) found = 1;
        end
        check("reach_idx100", 32'(found), 32'd1);
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        check("abort_to_idle", 32'({win_valid_a, busy_a, done_a}), 32'd0);

        // Restart, then reset during CAP
        start_frame(0);
        check("restart_fill0", 32'({rom_en_a, rom_addr_a, win_idx_a}), 32'({1'b1, 5'd0, 9'd0}));
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(posedge clk); #1;
            if (busy_a && rom_en_a && !win_valid_a && win_idx_a != 9'd0) found = 1;
        end
        check("reach_rq", 32'(found), 32'd1);
        @(posedge clk); #1;
        rst_a = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_frame_outs", 32'(outs_a), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0; start_a = 1'b0;
        @(posedge clk); #1;
        check("start_ignored_in_reset", 32'(busy_a), 32'd0);

        // Normal frame after reset release
        start_frame(0);
        wait_done(0, 1'b1, bub);

        // Parameter variant: one refill, zero-filled tail
        start_frame(1);
        wait_done(1, 1'b0, bub);
        check("bubbles_b", 32'(bub), 32'd4);
        start_frame(1);
        wait_done(1, 1'b1, bub);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ecg_win_sched.md
# ecg_win_sched

Window scheduler for the ECG input path. It owns the read port of the 32-bit-word ECG sample ROM and fetches words in order. It cuts the resulting bit stream into overlapping 7-bit windows at a fixed stride and hands them to the PE-array front end over a valid/ready handshake. Each frame runs from a start pulse to a done pulse, with backpressure and abort handled in-block.

## Interface
- DEPTH, 29: ROM words per frame
- ADDR_W, 5: ROM address width
- STRIDE, 2: bit advance per window, even, 2..8
- WIN, 7: window width in bits (fixed; documented only)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  drop current frame, return to IDLE
- rom_en  out  1  ROM read enable (combinational from state)
- rom_addr  out  ADDR_W  ROM word address
- rom_data  in  32  ROM read data; valid one cycle after rom_en
- win_data  out  7  current window, MSB = earliest bit
- win_valid  out  1  window available
- win_ready  in  1  consumer accepts
- win_last  out  1  qualifies final window of frame
- win_idx  out  9  index of current window
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final handshake

## Operation
- Buffer: hi/lo 32-bit registers form a 64-bit view {hi,lo}. pos (6-bit) is the bit offset from hi[31]. win_data = {hi,lo}[63-pos -: 7].
- NWIN = (DEPTH*32 - 7)/STRIDE + 1, using floor division; the default gives 461. win_idx counts 0..NWIN-1.
- nxt register holds the next ROM word address to fetch.
- IDLE: all outputs 0. When start=1, go to FILL0 and clear pos, nxt, and win_idx.
- FILL0: rom_en=1, rom_addr=0, then go to FILL1.
- FILL1: hi<=rom_data; rom_en=1, rom_addr=1; nxt<=2; then go to FILL2.
- FILL2: lo<=rom_data (lo<=0 when DEPTH=1), then go to STREAM.
- STREAM: win_valid=1. A handshake is win_valid & win_ready. On each handshake:
  - pos<=pos+STRIDE and win_idx<=win_idx+1.
  - If win_idx==NWIN-1, go to DONE.
  - Otherwise, if pos+STRIDE>=32, then hi<=lo, pos<=pos+STRIDE-32, and go to RQ.
- With no handshake, all registers hold and win_data stays stable.
- RQ: if nxt<DEPTH, rom_en=1 and rom_addr=nxt; otherwise rom_en=0. Then go to CAP.
- CAP: if nxt<DEPTH, lo<=rom_data and nxt<=nxt+1; otherwise lo<=0. Then go to STREAM.
- DONE: done=1, busy=1 for one cycle, then go to IDLE.
- win_last = win_valid & (win_idx==NWIN-1).
- rom_addr is 0 whenever rom_en=0.
- abort=1 in any state other than IDLE forces IDLE on the next edge. No done pulse is produced and any handshake in that cycle is discarded. abort has priority over the handshake.
- start while busy is ignored. start and abort together in IDLE leave the block in IDLE.
- rst=1 forces IDLE and clears all registers. All outputs read 0 on the cycle after the reset edge.

## Timing
- Start sampled at edge E0. FILL0 covers E0→E1, FILL1 E1→E2, FILL2 E2→E3. The first win_valid=1 appears in the cycle after E3.
- ROM latency is exactly 1 cycle. No word is read twice and none is skipped; addresses are issued strictly ascending 0..DEPTH-1.
- With default parameters and win_ready held at 1:
  - 16 windows per word, then 2 bubble cycles (RQ, CAP) per refill.
  - 28 refills per frame, so 461 handshakes plus 56 bubbles.
  - The done pulse comes one cycle after the 461st handshake.
- win_valid never drops without a handshake, except on abort or rst.
- Back-to-back frames: start may be asserted in the IDLE cycle right after DONE.

## Test plan
- Basic fetch:
  - Stimulus: ROM word0=0xA5A5A5A5, word1=0xFFFFFFFF, start pulse, ready=1.
  - Response: rom_addr 0 then 1 on consecutive cycles; first win_data=0x52 three cycles after start; second window 0x4B; window 15 (pos 30) = 0x3F.
- Full frame:
  - Stimulus: ready=1 for a complete frame.
  - Response: exactly 461 handshakes; win_last only on idx 460; done high for exactly one cycle right after; 29 distinct rom_addr reads 0..28; busy low afterwards.
- Backpressure:
  - Stimulus: win_ready toggles pseudo-randomly.
  - Response: win_data/win_idx hold while ready=0; output sequence identical to the ready=1 run.
- Abort:
  - Stimulus: abort at win_idx=100 while ready=1.
  - Response: IDLE next cycle, no done pulse, win_valid=0. A new start restarts at idx 0 with rom_addr 0.
- Reset mid-frame:
  - Stimulus: rst asserted during CAP.
  - Response: all outputs 0 on the following cycle. start ignored while rst=1; a normal frame follows release.
- Parameter variant:
  - Stimulus: STRIDE=4, DEPTH=2.
  - Response: NWIN=15; refill after 8 windows; no ROM read beyond addr 1; lo zero-filled at the tail; done after the 15th handshake.
